// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU opcodes, fetch FSM states and opcode screening
package cpu_pkg;

  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_LOAD  = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_STORE = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_MOV   = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_MAC   = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } if_state_e;

  function automatic logic opcode_is_legal(input logic [OPCODE_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_MOV) || (op == OP_MAC);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory and instruction-stream bundle of the fetch stage
interface if_stage_if #(
  parameter int ADDR_WIDTH   = 8,
  parameter int INSTR_WIDTH  = 16,
  parameter int OPCODE_WIDTH = cpu_pkg::OPCODE_W
);
  logic                    imem_req;
  logic [ADDR_WIDTH-1:0]   imem_addr;
  logic                    imem_gnt;
  logic                    imem_rvalid;
  logic [INSTR_WIDTH-1:0]  imem_rdata;

  logic                    instr_valid;
  logic                    instr_ready;
  logic [INSTR_WIDTH-1:0]  instr;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [ADDR_WIDTH-1:0]   instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, opcode, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, opcode, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/if_pc_reg.sv
// rtl/if_pc_reg.sv - program counter with reset value, increment enable and natural wrap
module if_pc_reg #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_inc,
  output logic [ADDR_WIDTH-1:0] o_pc
);

  logic [ADDR_WIDTH-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_WIDTH'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: request/grant/response fetch, instruction
// register with valid/ready hand-off, and illegal-opcode halt
module if_stage
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    INSTR_WIDTH  = 16,
  parameter int                    OPCODE_WIDTH = OPCODE_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  if_stage_if.master            bus,
  output logic                  illegal,
  output logic [ADDR_WIDTH-1:0] illegal_pc
);

  if_state_e               r_state;
  if_state_e               w_next;
  logic                    w_legal;
  logic                    w_accept;
  logic                    w_reject;
  logic [ADDR_WIDTH-1:0]   w_pc;
  logic [OPCODE_WIDTH-1:0] w_rdata_op;

  logic                    r_imem_req;
  logic                    r_instr_valid;
  logic [INSTR_WIDTH-1:0]  r_instr;
  logic [ADDR_WIDTH-1:0]   r_instr_pc;
  logic                    r_illegal;
  logic [ADDR_WIDTH-1:0]   r_illegal_pc;

  assign w_rdata_op = bus.imem_rdata[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign w_legal    = opcode_is_legal(OPCODE_W'(w_rdata_op));

  if_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_accept),
    .o_pc  (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // gnt is only looked at in REQ and rvalid only in WAIT, so strays elsewhere are dropped
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    case (r_state)
      S_IDLE: if (run) w_next = S_REQ;
      S_REQ:  if (bus.imem_gnt) w_next = S_WAIT;
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          w_accept = w_legal;
          w_reject = !w_legal;
          w_next   = w_legal ? S_HOLD : S_HALT;
        end
      end
      S_HOLD: if (bus.instr_ready) w_next = run ? S_REQ : S_IDLE;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_illegal     <= 1'b0;
      r_illegal_pc  <= '0;
    end else begin
      r_imem_req    <= (w_next == S_REQ);
      r_instr_valid <= (w_next == S_HOLD);
      if (w_accept) begin
        r_instr    <= bus.imem_rdata;
        r_instr_pc <= w_pc;
      end
      if (w_reject) begin
        r_illegal    <= 1'b1;
        r_illegal_pc <= w_pc;
      end
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = w_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.opcode      = r_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign bus.instr_pc    = r_instr_pc;
  assign illegal         = r_illegal;
  assign illegal_pc      = r_illegal_pc;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with randomized memory timing
module tb_if_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_a, run_b;
  logic       illegal_a, illegal_b;
  logic [7:0] illegal_pc_a, illegal_pc_b;

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_pc;
  logic [15:0] m_word;
  logic [7:0]  m_ipc;

  if_stage_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .OPCODE_WIDTH(3)) bus_a ();
  if_stage_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .OPCODE_WIDTH(3)) bus_b ();

  if_stage #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .OPCODE_WIDTH(3), .RESET_PC(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run_a), .bus(bus_a.master),
    .illegal(illegal_a), .illegal_pc(illegal_pc_a)
  );

  if_stage #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .OPCODE_WIDTH(3), .RESET_PC(8'hFE)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run_b), .bus(bus_b.master),
    .illegal(illegal_b), .illegal_pc(illegal_pc_b)
  );

  always #5 clk = ~clk;

  function automatic bit op_ok(input logic [2:0] op);
    return op inside {3'b000, 3'b001, 3'b010, 3'b100};
  endfunction

  function automatic logic [15:0] rand_legal();
    logic [2:0] ops [4];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100;
    return {ops[$urandom_range(0, 3)], 13'($urandom)};
  endfunction

  function automatic logic [15:0] rand_illegal();
    logic [2:0] ops [4];
    ops[0] = 3'b011; ops[1] = 3'b101; ops[2] = 3'b110; ops[3] = 3'b111;
    return {ops[$urandom_range(0, 3)], 13'($urandom)};
  endfunction

  task automatic wait_req();
    int n = 0;
    while (bus_a.imem_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus_a.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout: imem_req=%b want 1 after %0d cycles", bus_a.imem_req, n);
    end
  endtask

  // One fetch from request to response; spurious=1 sprinkles stray gnt/rvalid where they must be ignored
  task automatic serve(input int gd, input int rd, input logic [15:0] word, input bit spurious);
    run_a = 1'b1;
    wait_req();
    run_a = spurious ? 1'($urandom_range(0, 1)) : 1'b1;
    checks++;
    if (bus_a.imem_addr !== m_pc) begin
      errors++;
      $display("FAIL fetch_addr: got %h want %h", bus_a.imem_addr, m_pc);
    end
    for (int i = 0; i < gd; i++) begin
      bus_a.imem_gnt    = 1'b0;
      bus_a.imem_rvalid = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_a.imem_rdata  = rand_illegal();
      @(negedge clk);
      checks++;
      if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== m_pc) begin
        errors++;
        $display("FAIL req_stable: req=%b addr=%h want 1/%h", bus_a.imem_req, bus_a.imem_addr, m_pc);
      end
    end
    bus_a.imem_gnt    = 1'b1;
    bus_a.imem_rvalid = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
    bus_a.imem_rdata  = rand_illegal();
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      checks++;
      if ({bus_a.imem_req, bus_a.instr_valid, illegal_a} !== 3'b000) begin
        errors++;
        $display("FAIL wait_state: req/valid/illegal=%b want 000", {bus_a.imem_req, bus_a.instr_valid, illegal_a});
      end
      bus_a.imem_gnt    = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_a.imem_rvalid = (i == rd - 1);
      bus_a.imem_rdata  = (i == rd - 1) ? word : rand_illegal();
    end
    @(negedge clk);
    bus_a.imem_gnt    = 1'b0;
    bus_a.imem_rvalid = 1'b0;
    if (op_ok(word[15:13])) begin
      m_word = word;
      m_ipc  = m_pc;
      checks++;
      if (bus_a.instr_valid !== 1'b1 || bus_a.instr !== word || bus_a.opcode !== word[15:13] ||
          bus_a.instr_pc !== m_pc || bus_a.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL capture: valid=%b instr=%h op=%b pc=%h req=%b want 1/%h/%b/%h/0",
                 bus_a.instr_valid, bus_a.instr, bus_a.opcode, bus_a.instr_pc, bus_a.imem_req,
                 word, word[15:13], m_pc);
      end
    end else begin
      checks++;
      if (illegal_a !== 1'b1 || illegal_pc_a !== m_pc || bus_a.instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL illegal_trap: illegal=%b ipc=%h valid=%b want 1/%h/0",
                 illegal_a, illegal_pc_a, bus_a.instr_valid, m_pc);
      end
    end
  endtask

  task automatic accept(input int hold, input bit next_run);
    for (int i = 0; i < hold; i++) begin
      bus_a.instr_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_a.instr_valid !== 1'b1 || bus_a.instr !== m_word || bus_a.instr_pc !== m_ipc ||
          bus_a.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: valid=%b instr=%h pc=%h req=%b want 1/%h/%h/0",
                 bus_a.instr_valid, bus_a.instr, bus_a.instr_pc, bus_a.imem_req, m_word, m_ipc);
      end
    end
    bus_a.instr_ready = 1'b1;
    run_a = next_run;
    @(negedge clk);
    bus_a.instr_ready = 1'b0;
    m_pc = m_pc + 8'd1;
    checks++;
    if (bus_a.instr_valid !== 1'b0 || bus_a.imem_req !== next_run ||
        (next_run && bus_a.imem_addr !== m_pc)) begin
      errors++;
      $display("FAIL handshake: valid=%b req=%b addr=%h want 0/%b/%h",
               bus_a.instr_valid, bus_a.imem_req, bus_a.imem_addr, next_run, m_pc);
    end
    if (!next_run) begin
      repeat (2) @(negedge clk);
      checks++;
      if (bus_a.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_req: req=%b want 0", bus_a.imem_req);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (bus_a.imem_req !== 1'b0 || bus_a.imem_addr !== 8'h00 || bus_a.instr_valid !== 1'b0 ||
        bus_a.instr !== 16'h0000 || bus_a.instr_pc !== 8'h00 || illegal_a !== 1'b0 ||
        illegal_pc_a !== 8'h00 || bus_b.imem_addr !== 8'hFE || bus_b.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s: req=%b addr=%h valid=%b instr=%h ipc=%h ill=%b illpc=%h addr_b=%h want 0/00/0/0000/00/0/00/FE",
               tag, bus_a.imem_req, bus_a.imem_addr, bus_a.instr_valid, bus_a.instr,
               bus_a.instr_pc, illegal_a, illegal_pc_a, bus_b.imem_addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run_a = 1'b0; run_b = 1'b0;
    bus_a.imem_gnt = 1'b0; bus_a.imem_rvalid = 1'b0; bus_a.imem_rdata = '0; bus_a.instr_ready = 1'b0;
    bus_b.imem_gnt = 1'b0; bus_b.imem_rvalid = 1'b0; bus_b.imem_rdata = '0; bus_b.instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset_state");
    rst_n = 1'b1;
    m_pc  = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_first_fetch();
    serve(0, 1, 16'h4123, 1'b0);
    accept(0, 1'b1);
  endtask

  task automatic test_stall();
    serve(0, 1, rand_legal(), 1'b0);
    accept(5, 1'b1);
  endtask

  task automatic test_delays();
    serve(3, 4, rand_legal(), 1'b1);
    accept(1, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      serve($urandom_range(0, 3), $urandom_range(1, 4), rand_legal(), 1'b1);
      accept($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_wait();
    run_a = 1'b1;
    wait_req();
    bus_a.imem_gnt = 1'b1;
    @(negedge clk);
    bus_a.imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_wait");
    @(negedge clk);
    rst_n = 1'b1;
    run_a = 1'b0;
    m_pc  = 8'h00;
    @(negedge clk);
    bus_a.imem_rvalid = 1'b1;
    bus_a.imem_rdata  = rand_legal();
    @(negedge clk);
    bus_a.imem_rvalid = 1'b0;
    checks++;
    if (bus_a.instr_valid !== 1'b0 || bus_a.imem_req !== 1'b0 || bus_a.imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL late_rvalid: valid=%b req=%b addr=%h want 0/0/00",
               bus_a.instr_valid, bus_a.imem_req, bus_a.imem_addr);
    end
    serve(1, 2, rand_legal(), 1'b0);
    accept(0, 1'b1);
  endtask

  task automatic test_illegal();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_pc  = 8'h00;
    for (int k = 0; k < 5; k++) begin
      serve(0, 1, rand_legal(), 1'b0);
      accept(0, 1'b1);
    end
    serve(1, 2, {3'b011, 13'($urandom)}, 1'b1);
    checks++;
    if (illegal_pc_a !== 8'h05) begin
      errors++;
      $display("FAIL illegal_pc5: got %h want 05", illegal_pc_a);
    end
    run_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_a.imem_gnt    = 1'($urandom_range(0, 1));
      bus_a.imem_rvalid = 1'($urandom_range(0, 1));
      bus_a.imem_rdata  = rand_legal();
      bus_a.instr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (bus_a.imem_req !== 1'b0 || bus_a.instr_valid !== 1'b0 || illegal_a !== 1'b1) begin
        errors++;
        $display("FAIL halt_absorb: req=%b valid=%b illegal=%b want 0/0/1",
                 bus_a.imem_req, bus_a.instr_valid, illegal_a);
      end
    end
    bus_a.imem_gnt = 1'b0; bus_a.imem_rvalid = 1'b0; bus_a.instr_ready = 1'b0;
    run_a = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("illegal_cleared");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [3];
    int n;
    exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      run_b = 1'b1;
      n = 0;
      while (bus_b.imem_req !== 1'b1 && n < 8) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (bus_b.imem_req !== 1'b1 || bus_b.imem_addr !== exp_pc[k]) begin
        errors++;
        $display("FAIL wrap_req%0d: req=%b addr=%h want 1/%h", k, bus_b.imem_req, bus_b.imem_addr, exp_pc[k]);
      end
      bus_b.imem_gnt = 1'b1;
      @(negedge clk);
      bus_b.imem_gnt    = 1'b0;
      bus_b.imem_rvalid = 1'b1;
      bus_b.imem_rdata  = rand_legal();
      @(negedge clk);
      bus_b.imem_rvalid = 1'b0;
      checks++;
      if (bus_b.instr_valid !== 1'b1 || bus_b.instr_pc !== exp_pc[k] || illegal_b !== 1'b0) begin
        errors++;
        $display("FAIL wrap_pc%0d: valid=%b ipc=%h illegal=%b want 1/%h/0",
                 k, bus_b.instr_valid, bus_b.instr_pc, illegal_b, exp_pc[k]);
      end
      bus_b.instr_ready = 1'b1;
      @(negedge clk);
      bus_b.instr_ready = 1'b0;
    end
    run_b = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_delays();
    test_random();
    test_reset_mid_wait();
    test_illegal();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
